// File: rtl/dispatch_pkg.sv
// Shared definitions for the dispatch stage.
//   - RV32I major opcode constants
//   - unit_e / rob_type_e back-end routing enums, dispatch FSM state enum
//   - cdb_lookup: searches the CDB broadcast channels for a ROB tag
// cdb_lookup works on buses widened to fixed maximum sizes so it can be shared
// by any parametrisation with CDB_N <= CDB_MAX, ROB_IDX_W <= TAG_MAX and
// XLEN <= VAL_MAX.
package dispatch_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   localparam int CDB_MAX = 8;
   localparam int TAG_MAX = 8;
   localparam int VAL_MAX = 64;

   typedef enum logic [1:0] {UNIT_ALU = 2'd0, UNIT_LSB = 2'd1, UNIT_ROB = 2'd2} unit_e;
   typedef enum logic [1:0] {ROB_REG = 2'd0, ROB_STORE = 2'd1, ROB_BRANCH = 2'd2} rob_type_e;
   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

   typedef struct packed {
      logic               hit;
      logic [VAL_MAX-1:0] value;
   } cdb_hit_t;

   // Lowest-index matching channel wins: scanning downwards lets it overwrite.
   function automatic cdb_hit_t cdb_lookup(input logic [CDB_MAX-1:0]         valid,
                                           input logic [CDB_MAX*TAG_MAX-1:0] tags,
                                           input logic [CDB_MAX*VAL_MAX-1:0] values,
                                           input logic [TAG_MAX-1:0]         tag);
      cdb_hit_t r;
      r.hit   = 1'b0;
      r.value = '0;
      for (int i = CDB_MAX - 1; i >= 0; i--) begin
         if (valid[i] && (tags[i*TAG_MAX +: TAG_MAX] == tag)) begin
            r.hit   = 1'b1;
            r.value = values[i*VAL_MAX +: VAL_MAX];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/dispatch_stage_imm_gen.sv
// Combinational RV32I immediate generator.
//   inst_hi : instruction bits [31:7] (opcode bits are not needed here)
//   imm_i/imm_s/imm_b/imm_u/imm_j : sign-extended immediates per format
module imm_gen #(
   parameter int XLEN = 32
) (
   input  logic [24:0]     inst_hi,
   output logic [XLEN-1:0] imm_i,
   output logic [XLEN-1:0] imm_s,
   output logic [XLEN-1:0] imm_b,
   output logic [XLEN-1:0] imm_u,
   output logic [XLEN-1:0] imm_j
);
   // inst_hi[k] holds instruction bit k+7.
   assign imm_i = XLEN'($signed(inst_hi[24:13]));
   assign imm_s = XLEN'($signed({inst_hi[24:18], inst_hi[4:0]}));
   assign imm_b = XLEN'($signed({inst_hi[24], inst_hi[0], inst_hi[23:18], inst_hi[4:1], 1'b0}));
   assign imm_u = XLEN'($signed({inst_hi[24:5], 12'b0}));
   assign imm_j = XLEN'($signed({inst_hi[24], inst_hi[12:5], inst_hi[13], inst_hi[23:14], 1'b0}));
endmodule

// File: rtl/dispatch_stage.sv
// Registered RV32I decode/dispatch stage.
// Front end : in_valid/in_ready/in_inst/in_pc/in_pred_jump from ifetch.
// Operands  : rsX_index to the register file, rsX_dirty/tag/value back;
//             rob_qX_tag to the ROB, rob_qX_rdy/value back; CDB snooping.
// Back end  : one-deep uop register (out_*) with out_valid/out_ready.
// JALR      : target resolved at accept or via a WAIT state snooping the CDB;
//             redirect_valid/redirect_pc pulse for one cycle, jalr_stall in WAIT.
// Control   : rst (sync, active low), rdy (global hold), rollback (flush).
module dispatch_stage
   import dispatch_pkg::*;
#(
   parameter int ROB_IDX_W = 4,
   parameter int CDB_N     = 2,
   parameter int XLEN      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      rollback,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [31:0]               in_inst,
   input  logic [XLEN-1:0]           in_pc,
   input  logic                      in_pred_jump,
   output logic [4:0]                rs1_index,
   output logic [4:0]                rs2_index,
   input  logic                      rs1_dirty,
   input  logic [ROB_IDX_W-1:0]      rs1_tag,
   input  logic [XLEN-1:0]           rs1_value,
   input  logic                      rs2_dirty,
   input  logic [ROB_IDX_W-1:0]      rs2_tag,
   input  logic [XLEN-1:0]           rs2_value,
   output logic [ROB_IDX_W-1:0]      rob_q1_tag,
   input  logic                      rob_q1_rdy,
   input  logic [XLEN-1:0]           rob_q1_value,
   output logic [ROB_IDX_W-1:0]      rob_q2_tag,
   input  logic                      rob_q2_rdy,
   input  logic [XLEN-1:0]           rob_q2_value,
   input  logic                      rob_full,
   input  logic [ROB_IDX_W-1:0]      rob_free_tag,
   input  logic [CDB_N-1:0]          cdb_valid,
   input  logic [CDB_N*ROB_IDX_W-1:0] cdb_tag,
   input  logic [CDB_N*XLEN-1:0]     cdb_value,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [6:0]                out_opcode,
   output logic [2:0]                out_funct3,
   output logic                      out_funct7b5,
   output logic [4:0]                out_rd,
   output logic [XLEN-1:0]           out_imm,
   output logic [XLEN-1:0]           out_pc,
   output logic                      out_pred_jump,
   output logic [XLEN-1:0]           out_rs1_val,
   output logic                      out_rs1_wait,
   output logic [ROB_IDX_W-1:0]      out_rs1_tag,
   output logic [XLEN-1:0]           out_rs2_val,
   output logic                      out_rs2_wait,
   output logic [ROB_IDX_W-1:0]      out_rs2_tag,
   output logic [ROB_IDX_W-1:0]      out_rob_tag,
   output logic [1:0]                out_unit,
   output logic [1:0]                out_rob_type,
   output logic                      out_rob_ready,
   output logic                      out_is_store,
   output logic                      jalr_stall,
   output logic                      redirect_valid,
   output logic [XLEN-1:0]           redirect_pc
);

   state_e                state_p1;
   logic [ROB_IDX_W-1:0]  jalr_tag_p1;
   logic [XLEN-1:0]       jalr_off_p1;

   logic [6:0]            opcode;
   logic [XLEN-1:0]       imm_i, imm_s, imm_b, imm_u, imm_j;
   unit_e                 dec_unit;
   rob_type_e             dec_type;
   logic                  dec_rob_rdy, dec_store, dec_jalr;
   logic [4:0]            dec_rd;
   logic [XLEN-1:0]       dec_imm;

   logic [CDB_MAX-1:0]         cdb_v_w;
   logic [CDB_MAX*TAG_MAX-1:0] cdb_t_w;
   logic [CDB_MAX*VAL_MAX-1:0] cdb_d_w;
   cdb_hit_t              hit_q1, hit_q2, hit_w1, hit_w2, hit_jr;
   logic [XLEN:0]         res1, res2;
   logic                  accept;
   logic [XLEN-1:0]       tgt_now, tgt_wait;

   assign opcode     = in_inst[6:0];
   assign rs1_index  = in_inst[19:15];
   assign rs2_index  = in_inst[24:20];
   assign rob_q1_tag = rs1_tag;
   assign rob_q2_tag = rs2_tag;

   assign in_ready = rdy && (state_p1 == S_IDLE) && !rob_full && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .inst_hi (in_inst[31:7]),
      .imm_i   (imm_i),
      .imm_s   (imm_s),
      .imm_b   (imm_b),
      .imm_u   (imm_u),
      .imm_j   (imm_j)
   );

   always_comb begin
      dec_unit    = UNIT_ROB;
      dec_type    = ROB_REG;
      dec_rob_rdy = 1'b1;
      dec_store   = 1'b0;
      dec_jalr    = 1'b0;
      dec_rd      = 5'd0;
      dec_imm     = '0;
      case (opcode)
         OP_LUI:    begin dec_rd = in_inst[11:7]; dec_imm = imm_u; end
         OP_AUIPC:  begin dec_unit = UNIT_ALU; dec_rob_rdy = 1'b0; dec_rd = in_inst[11:7]; dec_imm = imm_u; end
         OP_JAL:    begin dec_unit = UNIT_ALU; dec_rob_rdy = 1'b0; dec_rd = in_inst[11:7]; dec_imm = imm_j; end
         // The uop only writes the link value; the target goes out via redirect.
         OP_JALR:   begin dec_rd = in_inst[11:7]; dec_imm = in_pc + XLEN'(4); dec_jalr = 1'b1; end
         OP_BRANCH: begin dec_unit = UNIT_ALU; dec_type = ROB_BRANCH; dec_rob_rdy = 1'b0; dec_imm = imm_b; end
         OP_LOAD:   begin dec_unit = UNIT_LSB; dec_rob_rdy = 1'b0; dec_rd = in_inst[11:7]; dec_imm = imm_i; end
         OP_STORE:  begin dec_unit = UNIT_LSB; dec_type = ROB_STORE; dec_store = 1'b1; dec_imm = imm_s; end
         OP_IMM:    begin dec_unit = UNIT_ALU; dec_rob_rdy = 1'b0; dec_rd = in_inst[11:7]; dec_imm = imm_i; end
         OP_OP:     begin dec_unit = UNIT_ALU; dec_rob_rdy = 1'b0; dec_rd = in_inst[11:7]; end
         default:   ;
      endcase
   end

   // Widen the CDB buses to the package's fixed lookup geometry.
   always_comb begin
      cdb_v_w = '0;
      cdb_t_w = '0;
      cdb_d_w = '0;
      for (int i = 0; i < CDB_N; i++) begin
         cdb_v_w[i]                     = cdb_valid[i];
         cdb_t_w[i*TAG_MAX +: TAG_MAX]  = TAG_MAX'(cdb_tag[i*ROB_IDX_W +: ROB_IDX_W]);
         cdb_d_w[i*VAL_MAX +: VAL_MAX]  = VAL_MAX'(cdb_value[i*XLEN +: XLEN]);
      end
   end

   assign hit_q1 = cdb_lookup(cdb_v_w, cdb_t_w, cdb_d_w, TAG_MAX'(rs1_tag));
   assign hit_q2 = cdb_lookup(cdb_v_w, cdb_t_w, cdb_d_w, TAG_MAX'(rs2_tag));
   assign hit_w1 = cdb_lookup(cdb_v_w, cdb_t_w, cdb_d_w, TAG_MAX'(out_rs1_tag));
   assign hit_w2 = cdb_lookup(cdb_v_w, cdb_t_w, cdb_d_w, TAG_MAX'(out_rs2_tag));
   assign hit_jr = cdb_lookup(cdb_v_w, cdb_t_w, cdb_d_w, TAG_MAX'(jalr_tag_p1));

   // Returns {wait, value}: regfile, then ROB, then CDB, else wait on the tag.
   function automatic logic [XLEN:0] resolve(input logic dirty, input logic [XLEN-1:0] rf_val,
                                             input logic q_rdy, input logic [XLEN-1:0] q_val,
                                             input cdb_hit_t hit);
      if (!dirty) return {1'b0, rf_val};
      if (q_rdy) return {1'b0, q_val};
      if (hit.hit) return {1'b0, XLEN'(hit.value)};
      return {1'b1, {XLEN{1'b0}}};
   endfunction

   assign res1     = resolve(rs1_dirty, rs1_value, rob_q1_rdy, rob_q1_value, hit_q1);
   assign res2     = resolve(rs2_dirty, rs2_value, rob_q2_rdy, rob_q2_value, hit_q2);
   assign tgt_now  = (res1[XLEN-1:0] + imm_i) & ~XLEN'(1);
   assign tgt_wait = (XLEN'(hit_jr.value) + jalr_off_p1) & ~XLEN'(1);

   // ---- stage boundary: decoded uop, operand wake-up and JALR FSM ----
   always_ff @(posedge clk) begin
      if (!rst || rollback) begin
         state_p1       <= S_IDLE;
         jalr_tag_p1    <= '0;
         jalr_off_p1    <= '0;
         jalr_stall     <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         out_valid      <= 1'b0;
         out_opcode     <= '0;
         out_funct3     <= '0;
         out_funct7b5   <= 1'b0;
         out_rd         <= '0;
         out_imm        <= '0;
         out_pc         <= '0;
         out_pred_jump  <= 1'b0;
         out_rs1_val    <= '0;
         out_rs1_wait   <= 1'b0;
         out_rs1_tag    <= '0;
         out_rs2_val    <= '0;
         out_rs2_wait   <= 1'b0;
         out_rs2_tag    <= '0;
         out_rob_tag    <= '0;
         out_unit       <= '0;
         out_rob_type   <= '0;
         out_rob_ready  <= 1'b0;
         out_is_store   <= 1'b0;
      end else if (rdy) begin
         redirect_valid <= 1'b0;
         if (accept) begin
            out_valid     <= 1'b1;
            out_opcode    <= opcode;
            out_funct3    <= in_inst[14:12];
            out_funct7b5  <= in_inst[30];
            out_rd        <= dec_rd;
            out_imm       <= dec_imm;
            out_pc        <= in_pc;
            out_pred_jump <= in_pred_jump;
            out_rs1_wait  <= res1[XLEN];
            out_rs1_val   <= res1[XLEN-1:0];
            out_rs1_tag   <= rs1_tag;
            out_rs2_wait  <= res2[XLEN];
            out_rs2_val   <= res2[XLEN-1:0];
            out_rs2_tag   <= rs2_tag;
            out_rob_tag   <= rob_free_tag;
            out_unit      <= dec_unit;
            out_rob_type  <= dec_type;
            out_rob_ready <= dec_rob_rdy;
            out_is_store  <= dec_store;
            if (dec_jalr) begin
               if (res1[XLEN]) begin
                  state_p1    <= S_WAIT;
                  jalr_stall  <= 1'b1;
                  jalr_tag_p1 <= rs1_tag;
                  jalr_off_p1 <= imm_i;
               end else begin
                  redirect_valid <= 1'b1;
                  redirect_pc    <= tgt_now;
               end
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end else if (out_valid) begin
            // Held uop: capture any operand the CDB broadcasts now.
            if (out_rs1_wait && hit_w1.hit) begin
               out_rs1_val  <= XLEN'(hit_w1.value);
               out_rs1_wait <= 1'b0;
            end
            if (out_rs2_wait && hit_w2.hit) begin
               out_rs2_val  <= XLEN'(hit_w2.value);
               out_rs2_wait <= 1'b0;
            end
         end
         // Accept is blocked in WAIT, so this never collides with the branch above.
         if (state_p1 == S_WAIT && hit_jr.hit) begin
            state_p1       <= S_IDLE;
            jalr_stall     <= 1'b0;
            redirect_valid <= 1'b1;
            redirect_pc    <= tgt_wait;
         end
      end
   end

endmodule

// File: doc/dispatch_stage.md
Name: dispatch_stage

Overview:
Registered decode/dispatch stage between ifetch and the RS/LSB/ROB back end. It decodes RV32I, resolves source operands from the register file, the ROB and N CDB broadcast channels, and holds the result in a one-deep output register with a valid/ready handshake. JALR target resolution is handled by an explicit stall FSM that snoops the CDB. This generalises the combinational decoder: parametrised ROB tag width and CDB channel count, registered output with back-pressure, and operand wake-up while stalled.

Parameters:
ROB_IDX_W, 4, ROB tag width; the ROB has 2**ROB_IDX_W entries.
CDB_N, 2, number of broadcast channels (ALU, LSB, ...).
XLEN, 32, datapath width.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active low
rdy  in  1  global enable; when 0, all state holds
rollback  in  1  misprediction flush
in_valid  in  1  instruction available from ifetch
in_ready  out  1  stage accepts instruction this cycle
in_inst  in  32  instruction word
in_pc  in  XLEN  instruction PC
in_pred_jump  in  1  predictor decision
rs1_index, rs2_index  out  5  combinational from in_inst[19:15] and in_inst[24:20]
rsX_dirty  in  1  register file busy bit, per source
rsX_tag  in  ROB_IDX_W  register file rename tag, per source
rsX_value  in  XLEN  register file value, per source
rob_qX_tag  out  ROB_IDX_W  equals rsX_tag
rob_qX_rdy  in  1  ROB entry complete, per source
rob_qX_value  in  XLEN  ROB entry value, per source
rob_full  in  1  no free ROB entry
rob_free_tag  in  ROB_IDX_W  next ROB tag to allocate
cdb_valid  in  CDB_N  per-channel broadcast valid
cdb_tag  in  CDB_N*ROB_IDX_W  packed tags; channel i at [i*W +: W]
cdb_value  in  CDB_N*XLEN  packed values
out_valid  out  1  dispatch uop valid
out_ready  in  1  back end consumes uop
out_opcode  out  7, out_funct3 out 3, out_funct7b5 out 1, out_rd out 5, out_imm out XLEN, out_pc out XLEN, out_pred_jump out 1
out_rsX_val  out  XLEN, out_rsX_wait out 1, out_rsX_tag out ROB_IDX_W  operand X in {1,2}
out_rob_tag  out  ROB_IDX_W  allocated tag
out_unit  out  2  0 = ALU RS, 1 = LSB, 2 = ROB only
out_rob_type  out  2  0 = reg write, 1 = store, 2 = branch
out_rob_ready  out  1  ROB entry already complete
out_is_store  out  1  store flag
jalr_stall  out  1  high in state WAIT
redirect_valid  out  1  one-cycle pulse
redirect_pc  out  XLEN  JALR target

Behaviour:
- Reset (rst == 0 at posedge): out_valid=0, state=IDLE, redirect_valid=0, jalr_stall=0. All data outputs = 0.
- rollback (rst high): same clearing as reset. Rollback has priority over accept, wake-up and redirect. A redirect is never pulsed in a rollback cycle.
- in_ready = rdy & state==IDLE & !rob_full & (!out_valid | out_ready).
- Accept when in_valid & in_ready. The uop is registered next edge, so latency is 1 cycle. out_rob_tag = rob_free_tag.
- Operand priority: !dirty -> regfile value; else rob_q_rdy -> ROB value; else the lowest-index CDB channel with a matching tag -> cdb value; else wait=1 and tag kept.
- Wake-up: while out_valid & !out_ready, any waiting operand whose tag matches a CDB channel captures the value and clears wait.
- Decode fields:
  - LUI: ROB-only, rob_ready=1, imm=U.
  - AUIPC, JAL: ALU.
  - JALR: ROB-only, imm=pc+4, rob_ready=1.
  - Branch: ALU, rd=0, type 2.
  - Load: LSB.
  - Store: LSB, rd=0, type 1, rob_ready=1.
  - OP-IMM (I-imm) and OP: ALU.
  - Unknown opcode: ROB-only, rd=0, rob_ready=1.
  - All immediates are sign-extended per RV32I.
- JALR FSM, states IDLE and WAIT:
  - rs1 resolved at accept: next cycle redirect_valid=1 with redirect_pc = (rs1+I-imm) & ~1. State stays IDLE.
  - rs1 pending at accept: go to WAIT; latch tag and offset; jalr_stall=1; in_ready=0.
  - In WAIT: on a CDB match, redirect_valid pulses the next cycle with (value+offset) & ~1, and the state returns to IDLE.
  - A CDB match in the same cycle as the JALR accept counts as resolved.
- Arithmetic is modulo 2**XLEN; wrap-around is ignored.

Decomposition:
- Shared package dispatch_pkg holds:
  - opcode constants;
  - unit_e and rob_type_e enums;
  - a function cdb_lookup(valid, tags, values, tag) returning hit and value.
- One natural sub-module, imm_gen: combinational immediate generator per format.

Test Plan:
1. `addi x1,x0,5` with operands clean, out_ready=1 -> next cycle out_valid=1, unit ALU, imm=5, rs1_wait=0, rob_tag=rob_free_tag.
2. `add` with rs1 dirty (tag 3), cdb ch1 tag 3 value 0x10 in the same cycle -> out_rs1_val=0x10, wait=0.
3. Operand waiting on tag 5 with out_ready=0 for 3 cycles, cdb ch0 tag 5 value 7 in cycle 2 -> rs1_wait clears and val=7; uop unchanged otherwise.
4. `jalr` at pc 0x100, rs1 pending tag 2, offset 0x21 -> jalr_stall=1, in_ready=0; cdb tag 2 value 0x200 -> redirect_pc=0x220, one-cycle pulse, back to IDLE.
5. rollback while in WAIT with out_valid=1 -> out_valid=0, jalr_stall=0; no redirect even if a matching cdb arrives the same cycle.
6. rob_full=1 or rdy=0 with in_valid=1 -> in_ready=0, no state change; rst low mid-stall -> all outputs zero next cycle.
